// File: rtl/hamming_decode_pipe.sv
// rtl/hamming_decode_pipe.sv - two-stage multi-lane SECDED decoder with valid/ready stream and saturating error counters
module hamming_decode_pipe #(
  parameter int DATA_WIDTH = 25,
  parameter int LANES = 1,
  parameter int CNT_WIDTH = 16,
  localparam int ADDR_WIDTH = $clog2(DATA_WIDTH + 1 + $clog2(DATA_WIDTH + 1)),
  localparam int CODED_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [LANES*CODED_WIDTH-1:0]    data_in_i,
  input  logic                            correct_en_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [LANES*DATA_WIDTH-1:0]     data_out_o,
  output logic [LANES*2-1:0]              num_errors_o,
  output logic [LANES*ADDR_WIDTH-1:0]     fault_location_o,
  input  logic                            count_clr_i,
  output logic [CNT_WIDTH-1:0]            corr_count_o,
  output logic [CNT_WIDTH-1:0]            uncorr_count_o
);

  localparam logic [CNT_WIDTH+31:0] CNT_MAX = {32'b0, {CNT_WIDTH{1'b1}}};

  // Data bits occupy every non-power-of-two position above 0, in ascending order.
  function automatic logic [DATA_WIDTH-1:0] unpack(input logic [CODED_WIDTH-1:0] c);
    int k;
    k = 0;
    unpack = '0;
    for (int i = 1; i < CODED_WIDTH; i++) begin
      if ((i & (i - 1)) != 0) begin
        unpack[k] = c[i];
        k++;
      end
    end
  endfunction

  logic                          s1_valid;
  logic [LANES*CODED_WIDTH-1:0]  s1_code;
  logic [LANES*ADDR_WIDTH-1:0]   s1_syn;
  logic [LANES-1:0]              s1_perr;
  logic                          s1_cen;
  logic                          s1_adv, s2_adv;

  logic [LANES*ADDR_WIDTH-1:0]   syn_c;
  logic [LANES-1:0]              perr_c;
  logic [LANES*DATA_WIDTH-1:0]   dout_c;
  logic [LANES*2-1:0]            nerr_c;
  logic [CODED_WIDTH-1:0]        lane_code;
  logic [ADDR_WIDTH-1:0]         lane_syn;
  logic [31:0]                   corr_add, uncorr_add;
  logic [CNT_WIDTH+31:0]         corr_sum, uncorr_sum;

  assign s2_adv     = !out_valid_o || out_ready_i;
  assign s1_adv     = !s1_valid || s2_adv;
  assign in_ready_o = s1_adv;

  always_comb begin
    syn_c  = '0;
    perr_c = '0;
    for (int n = 0; n < LANES; n++) begin
      for (int i = 1; i < CODED_WIDTH; i++) begin
        if (data_in_i[n*CODED_WIDTH + i])
          syn_c[n*ADDR_WIDTH +: ADDR_WIDTH] = syn_c[n*ADDR_WIDTH +: ADDR_WIDTH] ^ ADDR_WIDTH'(i);
      end
      perr_c[n] = ^data_in_i[n*CODED_WIDTH +: CODED_WIDTH];
    end
  end

  always_comb begin
    dout_c    = '0;
    nerr_c    = '0;
    lane_code = '0;
    lane_syn  = '0;
    for (int n = 0; n < LANES; n++) begin
      lane_code = s1_code[n*CODED_WIDTH +: CODED_WIDTH];
      lane_syn  = s1_syn[n*ADDR_WIDTH +: ADDR_WIDTH];
      if (!s1_perr[n] && lane_syn == '0)
        nerr_c[n*2 +: 2] = 2'd0;
      else if (s1_perr[n] && 32'(lane_syn) < CODED_WIDTH)
        nerr_c[n*2 +: 2] = 2'd1;
      else
        nerr_c[n*2 +: 2] = 2'd2;
      if (nerr_c[n*2 +: 2] == 2'd1 && s1_cen) begin
        for (int i = 0; i < CODED_WIDTH; i++)
          if (ADDR_WIDTH'(i) == lane_syn) lane_code[i] = ~lane_code[i];
      end
      dout_c[n*DATA_WIDTH +: DATA_WIDTH] = unpack(lane_code);
    end
  end

  // Counters look at the delivered beat, so they use the registered classification.
  always_comb begin
    corr_add   = '0;
    uncorr_add = '0;
    for (int n = 0; n < LANES; n++) begin
      if (num_errors_o[n*2 +: 2] == 2'd1) corr_add = corr_add + 32'd1;
      if (num_errors_o[n*2 +: 2] == 2'd2) uncorr_add = uncorr_add + 32'd1;
    end
    corr_sum   = {32'b0, corr_count_o} + {{CNT_WIDTH{1'b0}}, corr_add};
    uncorr_sum = {32'b0, uncorr_count_o} + {{CNT_WIDTH{1'b0}}, uncorr_add};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid         <= 1'b0;
      s1_code          <= '0;
      s1_syn           <= '0;
      s1_perr          <= '0;
      s1_cen           <= 1'b0;
      out_valid_o      <= 1'b0;
      data_out_o       <= '0;
      num_errors_o     <= '0;
      fault_location_o <= '0;
      corr_count_o     <= '0;
      uncorr_count_o   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid_i;
        if (in_valid_i) begin
          s1_code <= data_in_i;
          s1_syn  <= syn_c;
          s1_perr <= perr_c;
          s1_cen  <= correct_en_i;
        end
      end
      if (s2_adv) begin
        out_valid_o <= s1_valid;
        if (s1_valid) begin
          data_out_o       <= dout_c;
          num_errors_o     <= nerr_c;
          fault_location_o <= s1_syn;
        end
      end
      if (count_clr_i) begin
        corr_count_o   <= '0;
        uncorr_count_o <= '0;
      end else if (out_valid_o && out_ready_i) begin
        corr_count_o   <= (corr_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : corr_sum[CNT_WIDTH-1:0];
        uncorr_count_o <= (uncorr_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : uncorr_sum[CNT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_hamming_decode_pipe.sv
// tb/tb_hamming_decode_pipe.sv - scoreboard bench for hamming_decode_pipe (1-lane default and 2-lane 2-bit-counter configs)
module tb_hamming_decode_pipe;

  typedef struct packed {
    logic [24:0] d;
    logic [1:0]  n;
    logic [4:0]  loc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, correct_en, out_valid, out_ready, count_clr;
  logic [30:0] data_in;
  logic [24:0] data_out;
  logic [1:0]  num_errors;
  logic [4:0]  fault_location;
  logic [15:0] corr_count, uncorr_count;

  logic        in_valid2, in_ready2, cen2, out_valid2, out_ready2, clr2;
  logic [61:0] data_in2;
  logic [49:0] data_out2;
  logic [3:0]  nerr2;
  logic [9:0]  loc2;
  logic [1:0]  corr2, uncorr2;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hamming_decode_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .data_in_i(data_in), .correct_en_i(correct_en), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .data_out_o(data_out), .num_errors_o(num_errors),
    .fault_location_o(fault_location), .count_clr_i(count_clr),
    .corr_count_o(corr_count), .uncorr_count_o(uncorr_count)
  );

  hamming_decode_pipe #(.DATA_WIDTH(25), .LANES(2), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .data_in_i(data_in2), .correct_en_i(cen2), .out_valid_o(out_valid2),
    .out_ready_i(out_ready2), .data_out_o(data_out2), .num_errors_o(nerr2),
    .fault_location_o(loc2), .count_clr_i(clr2),
    .corr_count_o(corr2), .uncorr_count_o(uncorr2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: each Hamming parity bit covers the positions whose index has that bit set.
  function automatic logic [30:0] enc(input logic [24:0] d);
    logic [30:0] c;
    logic        p;
    int          k;
    c = '0;
    k = 0;
    for (int i = 1; i < 31; i++)
      if ((i & (i - 1)) != 0) begin
        c[i] = d[k];
        k++;
      end
    for (int b = 0; b < 5; b++) begin
      p = 1'b0;
      for (int i = 1; i < 31; i++)
        if (((i >> b) & 1) == 1) p = p ^ c[i];
      c[1 << b] = p;
    end
    c[0] = ^c;
    return c;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 64'd1, 64'd0);
      end else begin
        chk("data_out", 64'(data_out), 64'(q[0].d));
        chk("num_errors", 64'(num_errors), 64'(q[0].n));
        chk("fault_location", 64'(fault_location), 64'(q[0].loc));
        if (out_ready) q.delete(0);
      end
    end
  end

  task automatic send(input logic [30:0] c, input logic cen, input exp_t e);
    int t;
    t = 0;
    in_valid = 1'b1;
    data_in = c;
    correct_en = cen;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in = '0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] d;
    rst_n = 1'b0;
    in_valid = 1'b0; data_in = '0; correct_en = 1'b0; out_ready = 1'b1; count_clr = 1'b0;
    in_valid2 = 1'b0; data_in2 = '0; cen2 = 1'b0; out_ready2 = 1'b1; clr2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_corr", 64'(corr_count), 64'd0);
    chk("reset_uncorr", 64'(uncorr_count), 64'd0);
    chk("reset_corr2", 64'(corr2), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    send(31'h0, 1'b1, exp_t'{25'd0, 2'd0, 5'd0});
    chk("latency_c1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("latency_c2", 64'(out_valid), 64'd1);
    drain();
    chk("corr_after_clean", 64'(corr_count), 64'd0);

    send(31'h8, 1'b1, exp_t'{25'd0, 2'd1, 5'd3});
    drain();
    chk("corr_1", 64'(corr_count), 64'd1);
    send(31'h8, 1'b0, exp_t'{25'd1, 2'd1, 5'd3});
    drain();
    chk("corr_2", 64'(corr_count), 64'd2);
    send(31'h28, 1'b1, exp_t'{25'd3, 2'd2, 5'd6});
    send(31'h1, 1'b1, exp_t'{25'd0, 2'd1, 5'd0});
    drain();
    chk("corr_3", 64'(corr_count), 64'd3);
    chk("uncorr_1", 64'(uncorr_count), 64'd1);

    // Backpressure: output stalled for 4 cycles while 4 beats are offered.
    out_ready = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    d = 25'h1234567;
    send(enc(d), 1'b1, exp_t'{d, 2'd0, 5'd0});
    d = 25'h0ABCDEF;
    send(enc(d), 1'b1, exp_t'{d, 2'd0, 5'd0});
    @(negedge clk);
    chk("in_ready_full", 64'(in_ready), 64'd0);
    d = 25'(($urandom));
    send(enc(d), 1'b1, exp_t'{d, 2'd0, 5'd0});
    d = 25'(($urandom));
    send(enc(d) ^ 31'h400, 1'b1, exp_t'{d, 2'd1, 5'd10});
    drain();

    // Asynchronous reset with two beats in flight.
    out_ready = 1'b0;
    send(31'h28, 1'b1, exp_t'{25'd3, 2'd2, 5'd6});
    send(31'h8, 1'b1, exp_t'{25'd0, 2'd1, 5'd3});
    #1 rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_data", 64'(data_out), 64'd0);
    chk("arst_nerr", 64'(num_errors), 64'd0);
    chk("arst_loc", 64'(fault_location), 64'd0);
    chk("arst_corr", 64'(corr_count), 64'd0);
    chk("arst_uncorr", 64'(uncorr_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("no_stale_beat", 64'(out_valid), 64'd0);
    end
    d = 25'h1F0F0F0;
    send(enc(d), 1'b1, exp_t'{d, 2'd0, 5'd0});
    chk("post_rst_lat_c1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("post_rst_lat_c2", 64'(out_valid), 64'd1);
    drain();

    // Two lanes, 2-bit counters: saturation then clear winning over a handshake.
    cen2 = 1'b1;
    data_in2 = {31'h8, 31'h8};
    for (int i = 0; i < 3; i++) begin
      in_valid2 = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_corr2", 64'(corr2), 64'd3);
    chk("sat_uncorr2", 64'(uncorr2), 64'd0);
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    @(posedge clk);
    #1;
    chk("lane2_valid", 64'(out_valid2), 64'd1);
    chk("lane2_nerr", 64'(nerr2), 64'h5);
    chk("lane2_data", 64'(data_out2), 64'd0);
    chk("lane2_loc", 64'(loc2), 64'h63);
    clr2 = 1'b1;
    @(posedge clk);
    #1;
    clr2 = 1'b0;
    chk("clr_corr2", 64'(corr2), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_decode_pipe.md
# hamming_decode_pipe

Pipelined, multi-lane SECDED (extended Hamming) decoder with a valid/ready stream interface, a correct-or-detect-only mode and saturating error counters. Each beat carries LANES independent codewords. Each codeword is checked, optionally corrected and unpacked to DATA_WIDTH data bits. The block sits between a coded storage/link read port and the consuming datapath. It supersedes the single-word combinational decoder where throughput, backpressure and error telemetry are needed.

## Interface
- DATA_WIDTH, 25, data bits per codeword
- LANES, 1, codewords per beat (≥1)
- CNT_WIDTH, 16, width of each error counter
- Derived: ADDR_WIDTH = hamming_address_width(DATA_WIDTH) (gray_area_package); CODED_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  block accepts beat this cycle
- data_in_i  in  LANES*CODED_WIDTH  codewords; lane n at [n*CODED_WIDTH +: CODED_WIDTH]
- correct_en_i  in  1  1 = correct single errors; 0 = detect only; sampled with each accepted beat
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  consumer accepts output beat
- data_out_o  out  LANES*DATA_WIDTH  unpacked data per lane
- num_errors_o  out  LANES*2  per lane: 0 none, 1 single, 2 uncorrectable
- fault_location_o  out  LANES*ADDR_WIDTH  per lane syndrome (bit position of single error)
- count_clr_i  in  1  synchronous clear of both counters
- corr_count_o  out  CNT_WIDTH  lanes with single errors delivered (saturating)
- uncorr_count_o  out  CNT_WIDTH  lanes with uncorrectable errors delivered (saturating)

## Operation
- Codeword layout: bit 0 = overall parity; power-of-two positions 1,2,4,… = Hamming parity; data bits fill the remaining positions ascending (data bit 0 at position 3, bit 1 at 5, bit 2 at 6, …).
- Stage 1 (syndrome), per lane:
  - syndrome = XOR of the indices of all set bits in positions 1..CODED_WIDTH-1.
  - parity_err = XOR of all CODED_WIDTH bits; 0 for a valid word.
  - Register the codeword, syndrome, parity_err and correct_en.
- Stage 2 (classify/correct), per lane:
  - parity_err=0, syndrome=0 → 0 errors.
  - parity_err=1, syndrome<CODED_WIDTH → 1 error at position syndrome (syndrome 0 = bit 0 itself, data unaffected).
  - parity_err=0, syndrome≠0 → 2 (double error).
  - parity_err=1, syndrome≥CODED_WIDTH → 2 (multi-bit error aliasing to a nonexistent position).
  - On a 1-error classification with correct_en=1, invert the codeword bit at syndrome before unpacking. Otherwise unpack the raw codeword.
  - fault_location_o always carries the syndrome, whatever the classification.
- Counters update on output handshake (out_valid_o & out_ready_i):
  - corr_count += number of lanes with num_errors=1.
  - uncorr_count += number of lanes with num_errors=2.
  - Each counter saturates at all-ones and never wraps.
  - count_clr_i has priority: a counter takes the value 0 even if a handshake occurs in the same cycle.

## Timing
- Two register stages; latency is 2 cycles from input handshake to out_valid_o when there is no stall. Throughput is 1 beat/cycle.
- Stage 2 advances when it is empty or out_ready_i=1. Stage 1 advances when it is empty or stage 2 advances.
- in_ready_o = stage 1 empty OR stage 2 advancing. It is combinational from out_ready_i; there is no combinational path from in_valid_i.
- A held output stays stable (data, num_errors, fault_location) while out_valid_o=1 and out_ready_i=0.
- Bubbles collapse: an empty stage accepts new data regardless of downstream stall.
- Beats are delivered in order with none lost or duplicated. At most 2 beats are in flight.
- Reset (asynchronous, any time, including mid-stream):
  - Stage valids, out_valid_o, data_out_o, num_errors_o, fault_location_o and both counters go to 0.
  - in_ready_o = 1 after reset deasserts.
  - In-flight beats are discarded.

## Test plan
- Config DATA_WIDTH=25 (ADDR_WIDTH=5, CODED_WIDTH=31), LANES=1. All-zero codeword → after 2 cycles: data 0, num_errors 0, location 0, counters unchanged.
- All-zero codeword with position 3 flipped, correct_en=1 → num_errors 1, location 3, data 0x0000000, corr_count 1. Same word with correct_en=0 → data 0x0000001, corr_count 2.
- Zero codeword with positions 3 and 5 flipped → num_errors 2, location 6, data 0x0000003 uncorrected, uncorr_count 1. Bit 0 only flipped → num_errors 1, location 0, data 0.
- Stream 4 beats with out_ready_i low for the first 4 cycles → in_ready_o drops once 2 beats are held. After release, all 4 beats emerge in order at 1/cycle with stable data while stalled.
- CNT_WIDTH=2, LANES=2, 3 beats each with single errors in both lanes → corr_count 3 (saturated). count_clr_i asserted during a further error handshake → corr_count 0.
- Assert rst_n low with 2 beats in flight → all outputs 0 asynchronously. No stale beat appears after release. The next beat decodes with 2-cycle latency.
